// File: rtl/vga_pkg.sv
// Shared definitions for the VGA layer compositor: RGB slice packing, FSM states, defaults.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;

  // Background transition controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WIPE  = 2'd2
  } comp_state_e;

  // LSB position of packed {R,G,B} entry idx in a flattened colour bus
  function automatic int unsigned rgb_lsb(input int unsigned idx, input int unsigned color_w);
    return idx * 3 * color_w;
  endfunction

endpackage

// File: rtl/sprite_priority_mux.sv
// Combinational sprite selector: lowest-index asserted hit wins.
module sprite_priority_mux
  import vga_pkg::*;
#(
  parameter int unsigned NUM_SPR = 2,
  parameter int unsigned COLOR_W = 2
) (
  input  logic [NUM_SPR-1:0]           spr_hit_i,
  input  logic [NUM_SPR*3*COLOR_W-1:0] spr_rgb_i,
  output logic                         hit_any_o,
  output logic [3*COLOR_W-1:0]         rgb_o
);

  localparam int unsigned RGB_W = 3 * COLOR_W;

  // Scan from highest to lowest index so the lowest asserted hit is written last
  always_comb begin
    hit_any_o = 1'b0;
    rgb_o     = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (spr_hit_i[i]) begin
        hit_any_o = 1'b1;
        rgb_o     = spr_rgb_i[rgb_lsb(i, COLOR_W) +: RGB_W];
      end
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Merges background generators and sprite layers into one registered RGB stream,
// with frame-synchronised background changes played as an optional left-to-right wipe.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int unsigned COLOR_W   = 2,
  parameter int unsigned NUM_BG    = 4,
  parameter int unsigned NUM_SPR   = 2,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned WIPE_STEP = 32,
  parameter int unsigned FRAME_W   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SEL_W-1:0]             bg_sel,
  input  logic [NUM_BG*3*COLOR_W-1:0]  bg_rgb,
  input  logic [NUM_SPR*3*COLOR_W-1:0] spr_rgb,
  input  logic [NUM_SPR-1:0]           spr_hit,
  input  logic                         video_active,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic [9:0]                   pix_x,
  output logic [3*COLOR_W-1:0]         rgb_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic [FRAME_W-1:0]           frame_cnt,
  output logic                         busy
);

  localparam int unsigned RGB_W = 3 * COLOR_W;
  localparam int unsigned WX_W  = 11;
  localparam int unsigned WS_W  = WX_W + 1;

  logic [SEL_W-1:0]   sel_meta_q, sel_s_q;
  logic               vsync_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  comp_state_e        state_q;
  logic [SEL_W-1:0]   cur_sel_q, next_sel_q;
  logic [WX_W-1:0]    wipe_x_q;
  logic               busy_q;
  logic [RGB_W-1:0]   rgb_q;
  logic               hsync_q, vsync_out_q;

  logic               frame_tick_c;
  logic               sel_ok_c;
  logic [WS_W-1:0]    wipe_x_d;
  logic               wipe_done_c;
  logic [SEL_W-1:0]   pick_c;
  logic [RGB_W-1:0]   bg_pix_c;
  logic               spr_hit_any_c;
  logic [RGB_W-1:0]   spr_pix_c;

  // Two-flop synchroniser for the pin-driven background select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta_q <= '0;
      sel_s_q    <= '0;
    end else begin
      sel_meta_q <= bg_sel;
      sel_s_q    <= sel_meta_q;
    end
  end

  // vsync history for rising-edge detection, and the frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vsync_q <= vsync_in;
      if (frame_tick_c) frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
    end
  end

  assign frame_tick_c = vsync_in & ~vsync_q;
  assign sel_ok_c     = (32'(sel_s_q) < NUM_BG);
  assign wipe_x_d     = {1'b0, wipe_x_q} + WS_W'(WIPE_STEP);
  assign wipe_done_c  = (wipe_x_d >= WS_W'(H_ACTIVE));

  // Background transition FSM: arm on a new valid select, switch or wipe on frame ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_sel_q  <= '0;
      next_sel_q <= '0;
      wipe_x_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if ((sel_s_q != cur_sel_q) && sel_ok_c) begin
            next_sel_q <= sel_s_q;
            state_q    <= ST_ARMED;
            busy_q     <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (frame_tick_c) begin
            if (WIPE_STEP == 0) begin
              cur_sel_q <= next_sel_q;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end else begin
              wipe_x_q <= '0;
              state_q  <= ST_WIPE;
            end
          end
        end
        ST_WIPE: begin
          if (frame_tick_c) begin
            if (wipe_done_c) begin
              cur_sel_q <= next_sel_q;
              wipe_x_q  <= '0;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end else begin
              wipe_x_q <= wipe_x_d[WX_W-1:0];
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Columns left of the wipe front already show the incoming background
  assign pick_c = ((state_q == ST_WIPE) && (WX_W'(pix_x) < wipe_x_q)) ? next_sel_q : cur_sel_q;

  // Background source mux
  always_comb begin
    bg_pix_c = '0;
    for (int i = 0; i < NUM_BG; i++) begin
      if (pick_c == SEL_W'(i)) bg_pix_c = bg_rgb[rgb_lsb(i, COLOR_W) +: RGB_W];
    end
  end

  sprite_priority_mux #(
    .NUM_SPR (NUM_SPR),
    .COLOR_W (COLOR_W)
  ) u_spr_mux (
    .spr_hit_i (spr_hit),
    .spr_rgb_i (spr_rgb),
    .hit_any_o (spr_hit_any_c),
    .rgb_o     (spr_pix_c)
  );

  // Output stage: colour and syncs registered together so they stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_out_q <= 1'b0;
    end else begin
      hsync_q     <= hsync_in;
      vsync_out_q <= vsync_in;
      if (!video_active)      rgb_q <= '0;
      else if (spr_hit_any_c) rgb_q <= spr_pix_c;
      else                    rgb_q <= bg_pix_c;
    end
  end

  assign rgb_out   = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_out_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Randomised bench for vga_layer_compositor: a wiping instance (defaults) and an
// instant-switch instance (NUM_BG=3, WIPE_STEP=0, FRAME_W=4) share the stimulus and
// are both checked every cycle against a frame-level behavioural model.
module tb_vga_layer_compositor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  bg_sel;
  logic [23:0] bg_rgb;
  logic [11:0] spr_rgb;
  logic [1:0]  spr_hit;
  logic        video_active, hsync_in, vsync_in;
  logic [9:0]  pix_x;

  logic [5:0]  rgb_a, rgb_b;
  logic        hs_a, vs_a, busy_a, hs_b, vs_b, busy_b;
  logic [9:0]  fc_a;
  logic [3:0]  fc_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_layer_compositor u_dut_a (
    .clk (clk), .rst_n (rst_n), .bg_sel (bg_sel), .bg_rgb (bg_rgb),
    .spr_rgb (spr_rgb), .spr_hit (spr_hit), .video_active (video_active),
    .hsync_in (hsync_in), .vsync_in (vsync_in), .pix_x (pix_x),
    .rgb_out (rgb_a), .hsync_out (hs_a), .vsync_out (vs_a),
    .frame_cnt (fc_a), .busy (busy_a)
  );

  vga_layer_compositor #(
    .NUM_BG (3), .WIPE_STEP (0), .FRAME_W (4)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n), .bg_sel (bg_sel), .bg_rgb (bg_rgb[17:0]),
    .spr_rgb (spr_rgb), .spr_hit (spr_hit), .video_active (video_active),
    .hsync_in (hsync_in), .vsync_in (vsync_in), .pix_x (pix_x),
    .rgb_out (rgb_b), .hsync_out (hs_b), .vsync_out (vs_b),
    .frame_cnt (fc_b), .busy (busy_b)
  );

  // Per-instance configuration
  int cfg_nbg[2]   = '{4, 3};
  int cfg_step[2]  = '{32, 0};
  int cfg_fmod[2]  = '{1024, 16};
  int h_active     = 640;

  // Model state: 0 = steady, 1 = waiting for next frame, 2 = wiping
  int m_mode[2], m_cur[2], m_next[2], m_frames[2], m_fc[2];
  int m_sync1[2], m_sync2[2];
  bit m_vs_prev[2];

  int e_rgb[2], e_hs[2], e_vs[2], e_busy[2], e_fc[2];
  int vcnt, vper;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_cur[k] = 0; m_next[k] = 0; m_frames[k] = 0; m_fc[k] = 0;
      m_sync1[k] = 0; m_sync2[k] = 0; m_vs_prev[k] = 1'b0;
    end
  endtask

  // Expected outputs for the coming edge, then advance the model across it
  task automatic predict_and_advance();
    int  src;
    bit  tick;
    for (int k = 0; k < 2; k++) begin
      src = (m_mode[k] == 2 && int'(pix_x) < m_frames[k] * cfg_step[k]) ? m_next[k] : m_cur[k];
      if (!video_active)   e_rgb[k] = 0;
      else if (spr_hit[0]) e_rgb[k] = int'(spr_rgb[5:0]);
      else if (spr_hit[1]) e_rgb[k] = int'(spr_rgb[11:6]);
      else                 e_rgb[k] = int'(bg_rgb[src*6 +: 6]);
      e_hs[k] = int'(hsync_in);
      e_vs[k] = int'(vsync_in);

      tick = vsync_in && !m_vs_prev[k];
      case (m_mode[k])
        0: if (m_sync2[k] != m_cur[k] && m_sync2[k] < cfg_nbg[k]) begin
             m_next[k] = m_sync2[k];
             m_mode[k] = 1;
           end
        1: if (tick) begin
             if (cfg_step[k] == 0) begin
               m_cur[k]  = m_next[k];
               m_mode[k] = 0;
             end else begin
               m_frames[k] = 0;
               m_mode[k]   = 2;
             end
           end
        default: if (tick) begin
             m_frames[k]++;
             if (m_frames[k] * cfg_step[k] >= h_active) begin
               m_cur[k]    = m_next[k];
               m_frames[k] = 0;
               m_mode[k]   = 0;
             end
           end
      endcase
      if (tick) m_fc[k] = (m_fc[k] + 1) % cfg_fmod[k];
      m_vs_prev[k] = vsync_in;
      m_sync2[k]   = m_sync1[k];
      m_sync1[k]   = int'(bg_sel);
      e_busy[k]    = (m_mode[k] != 0) ? 1 : 0;
      e_fc[k]      = m_fc[k];
    end
  endtask

  task automatic check_outputs();
    chk("rgb_a",   32'(rgb_a),  32'(e_rgb[0]));
    chk("hsync_a", 32'(hs_a),   32'(e_hs[0]));
    chk("vsync_a", 32'(vs_a),   32'(e_vs[0]));
    chk("busy_a",  32'(busy_a), 32'(e_busy[0]));
    chk("frame_a", 32'(fc_a),   32'(e_fc[0]));
    chk("rgb_b",   32'(rgb_b),  32'(e_rgb[1]));
    chk("hsync_b", 32'(hs_b),   32'(e_hs[1]));
    chk("vsync_b", 32'(vs_b),   32'(e_vs[1]));
    chk("busy_b",  32'(busy_b), 32'(e_busy[1]));
    chk("frame_b", 32'(fc_b),   32'(e_fc[1]));
  endtask

  // Called at a negedge with inputs already set; returns at the following negedge
  task automatic step_cycle();
    predict_and_advance();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst_rgb_a",  32'(rgb_a),  32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_fc_a",   32'(fc_a),   32'd0);
    chk("rst_sync_a", 32'({hs_a, vs_a}), 32'd0);
    chk("rst_rgb_b",  32'(rgb_b),  32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_fc_b",   32'(fc_b),   32'd0);
  endtask

  // Asynchronous reset asserted between edges, held over one edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic randomise_inputs();
    vcnt++;
    if (vcnt >= vper) begin
      vcnt = 0;
      vper = $urandom_range(5, 9);
    end
    vsync_in     = (vcnt < 2);
    hsync_in     = 1'($urandom_range(0, 1));
    pix_x        = 10'($urandom_range(0, 700));
    bg_rgb       = 24'($urandom());
    spr_rgb      = 12'($urandom());
    spr_hit[0]   = ($urandom_range(0, 3) == 0);
    spr_hit[1]   = ($urandom_range(0, 3) == 0);
    video_active = ($urandom_range(0, 7) != 0);
    if ($urandom_range(0, 149) == 0) bg_sel = 2'($urandom_range(0, 3));
  endtask

  initial begin
    bit did_mid_reset;
    rst_n = 1'b0;
    bg_sel = 2'd0; bg_rgb = 24'hA5C3_96; spr_rgb = '0; spr_hit = '0;
    video_active = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; pix_x = '0;
    vcnt = 0; vper = 7;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    // First cycle after release shows background 0
    step_cycle();

    // Sprite priority and blanking
    spr_hit = 2'b11; spr_rgb = {6'h01, 6'h3F};
    step_cycle();
    spr_hit = 2'b10;
    step_cycle();
    video_active = 1'b0; spr_hit = 2'b11;
    step_cycle();
    video_active = 1'b1; spr_hit = 2'b00;

    // Directed 0 -> 2 request, then randomised traffic
    bg_sel = 2'd2;
    did_mid_reset = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (!did_mid_reset && c > 2500 && e_busy[0] == 1 && m_mode[0] == 2) begin
        did_mid_reset = 1'b1;
        do_reset();
      end
      randomise_inputs();
      step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_layer_compositor.md
# vga_layer_compositor

Parametrised pixel compositor for the VGA output path. It merges NUM_BG background generators and NUM_SPR sprite layers into one registered RGB stream aligned with hsync/vsync. Background changes are frame-synchronised and can be played as a left-to-right wipe. It sits between the hvsync_generator/pattern generators and the TinyVGA PMOD pin mapping, and replaces the ad-hoc colour mux and free-running counter in the top level.

## Interface
Parameters:
- COLOR_W, 2: bits per colour channel.
- NUM_BG, 4: number of background sources (≥1).
- NUM_SPR, 2: number of sprite layers (≥1).
- SEL_W, 2: width of bg_sel; 2**SEL_W ≥ NUM_BG.
- H_ACTIVE, 640: visible pixels per line.
- WIPE_STEP, 32: wipe advance in pixels per frame; 0 = instant switch.
- FRAME_W, 10: frame counter width.

Ports:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk, input, 1: pixel clock.
- rst_n, input, 1: asynchronous active-low reset.
- bg_sel, input, SEL_W: requested background; asynchronous (pin-driven).
- bg_rgb, input, NUM_BG*3*COLOR_W: packed {R,G,B} per source; source i at slice i.
- spr_rgb, input, NUM_SPR*3*COLOR_W: packed sprite colours, same packing.
- spr_hit, input, NUM_SPR: sprite i covers the current pixel.
- video_active, input, 1: display enable.
- hsync_in, vsync_in, input, 1 each: from hvsync_generator.
- pix_x, input, 10: current column.
- rgb_out, output, 3*COLOR_W: {R,G,B}, registered.
- hsync_out, vsync_out, output, 1 each: syncs delayed to match rgb_out.
- frame_cnt, output, FRAME_W: frames since reset.
- busy, output, 1: high while a change is ARMED or in WIPE.

## Operation
- bg_sel passes through a 2-flop synchroniser (reset 0) to give sel_s.
- Frame tick: a one-cycle pulse on the rising edge of vsync_in, detected with a registered copy of vsync_in.
- frame_cnt increments on each frame tick and wraps from 2**FRAME_W-1 to 0.
- FSM with states IDLE, ARMED and WIPE, plus registers cur_sel, next_sel and wipe_x (11 bits).
  - IDLE: if sel_s ≠ cur_sel and sel_s < NUM_BG, set next_sel to sel_s and go to ARMED. An out-of-range sel_s is ignored.
  - ARMED: on a frame tick, if WIPE_STEP = 0, set cur_sel to next_sel and go to IDLE. Otherwise set wipe_x to 0 and go to WIPE.
  - WIPE: on each frame tick, wipe_x increases by WIPE_STEP. If the new value is ≥ H_ACTIVE, set cur_sel to next_sel, clear wipe_x and go to IDLE.
  - bg_sel changes while ARMED or WIPE are ignored. The FSM re-evaluates sel_s in IDLE on the cycle after returning.
- Background pick: in WIPE with pix_x < wipe_x, use next_sel. Otherwise use cur_sel.
- Pixel priority:
  1. If video_active = 0, the output is all zero.
  2. Otherwise, the lowest-index asserted spr_hit wins and its spr_rgb is used.
  3. Otherwise, the picked background is used.
- busy = (state ≠ IDLE).

## Timing
- rgb_out, hsync_out and vsync_out have 1-cycle latency from the inputs sampled with them.
  - All three are registered in the same stage, so sync alignment is exact.
- bg_sel to FSM latency is 2 cycles (synchroniser), plus 1 cycle to reach ARMED.
- The visible switch lands on the first frame tick after ARMED. A wipe takes ceil(H_ACTIVE/WIPE_STEP) frames; 20 at the defaults.
- Reset values:
  - rgb_out, hsync_out, vsync_out, frame_cnt and busy are 0.
  - cur_sel, next_sel and wipe_x are 0; the state is IDLE; the synchroniser and vsync history are 0.
- Reset mid-wipe: the block returns immediately to background 0 with no transition.
- A frame tick in the same cycle as entering ARMED is not counted. The first counted tick is the next one.

## Structure
- Shared package `vga_pkg` holds:
  - the rgb field packing helper, slice index = i*3*COLOR_W;
  - the FSM state enum (IDLE/ARMED/WIPE);
  - the H_ACTIVE default of 640.
- Sub-module `sprite_priority_mux` takes NUM_SPR, COLOR_W, spr_hit and spr_rgb. It outputs hit_any and the winning rgb, and is combinational.
- The FSM, counters and output register stay in the top module.

## Test plan
- Reset with bg_sel=0 and video_active=1: after release, rgb_out equals bg_rgb slice 0 one cycle later; frame_cnt is 0 and busy is 0.
- WIPE_STEP=32, bg_sel 0→2:
  - busy rises 3 cycles later;
  - at tick+1 frame, pixels at pix_x<32 show source 2 and pixels at pix_x≥32 show source 0;
  - after 20 ticks cur_sel=2 and busy=0.
- WIPE_STEP=0, bg_sel→1: the full switch lands exactly at the next vsync rising edge, with no mid-frame tear.
- spr_hit=2'b11 with spr_rgb0=6'h3F and spr_rgb1=6'h01: rgb_out=6'h3F. With video_active=0, rgb_out=0 regardless of sprite hits.
- bg_sel toggles 1→3 mid-wipe: the wipe completes to 1, then a new wipe to 3 starts on the following tick. With NUM_BG=3, bg_sel=3 never sets busy.
- Frame counter wrap: with FRAME_W=4, after 16 frame ticks frame_cnt=0. Over 64 cycles, hsync_out and vsync_out equal hsync_in and vsync_in delayed by exactly 1 cycle.
